// File: rtl/bf16_pkg.sv
// Shared BF16 types and constants for the accumulator slice.
package bf16_pkg;

  typedef struct packed {
    logic       s;
    logic [7:0] e;
    logic [6:0] m;
  } bf16_t;

  localparam bf16_t BF16_ZERO = '{s: 1'b0, e: 8'h00, m: 7'h00};
  localparam bf16_t BF16_ONE  = '{s: 1'b0, e: 8'h7f, m: 7'h00};

endpackage

// File: rtl/bf16_add.sv
// Combinational BF16 adder: round-to-nearest-even, subnormals flushed to zero,
// canonical quiet NaN (0,ff,40) on any NaN input or inf - inf.
module bf16_add
  import bf16_pkg::*;
(
  input  bf16_t      a,
  input  bf16_t      b,
  output logic       s_o,
  output logic [7:0] e_o,
  output logic [6:0] m_o
);

  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        swap, eff_sub;
  bf16_t       big;
  logic [7:0]  sml_e, diff, diff_c;
  logic [6:0]  sml_m;
  logic [26:0] sh;
  logic [10:0] bx, sx;
  logic [11:0] sum;
  logic [9:0]  n;
  logic [3:0]  lz;
  logic signed [9:0] ex;
  logic [7:0]  frac;
  logic        rup;

  assign a_nan  = (a.e == 8'hff) && (a.m != 7'h00);
  assign b_nan  = (b.e == 8'hff) && (b.m != 7'h00);
  assign a_inf  = (a.e == 8'hff) && (a.m == 7'h00);
  assign b_inf  = (b.e == 8'hff) && (b.m == 7'h00);
  assign a_zero = (a.e == 8'h00);
  assign b_zero = (b.e == 8'h00);

  assign swap    = {b.e, b.m} > {a.e, a.m};
  assign big     = swap ? b : a;
  assign sml_e   = swap ? a.e : b.e;
  assign sml_m   = swap ? a.m : b.m;
  assign diff    = big.e - sml_e;
  assign diff_c  = (diff > 8'd26) ? 8'd26 : diff;
  assign eff_sub = a.s ^ b.s;

  // 8 significant + 3 guard bits; everything shifted below that folds into sticky
  assign sh  = {1'b1, sml_m, 19'b0} >> diff_c;
  assign bx  = {1'b1, big.m, 3'b000};
  assign sx  = {sh[26:17], sh[16] | (|sh[15:0])};
  assign sum = eff_sub ? ({1'b0, bx} - {1'b0, sx}) : ({1'b0, bx} + {1'b0, sx});

  always_comb begin
    lz = 4'd0;
    for (int i = 0; i < 11; i++)
      if (sum[i]) lz = 4'(10 - i);
    if (sum[11]) begin
      n  = {sum[10:2], sum[1] | sum[0]};
      ex = $signed({2'b00, big.e}) + 10'sd1;
    end else begin
      n  = 10'(sum[10:0] << lz);
      ex = $signed({2'b00, big.e}) - $signed({6'b0, lz});
    end
    rup  = n[2] & (n[1] | n[0] | n[3]);
    frac = {1'b0, n[9:3]} + 8'(rup);
    if (frac[7]) ex = ex + 10'sd1;
  end

  always_comb begin
    s_o = 1'b0;
    e_o = 8'h00;
    m_o = 7'h00;
    if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
      e_o = 8'hff;
      m_o = 7'h40;
    end else if (a_inf) begin
      {s_o, e_o, m_o} = a;
    end else if (b_inf) begin
      {s_o, e_o, m_o} = b;
    end else if (a_zero && b_zero) begin
      s_o = a.s & b.s;
    end else if (a_zero) begin
      {s_o, e_o, m_o} = b;
    end else if (b_zero) begin
      {s_o, e_o, m_o} = a;
    end else if (sum == 12'd0) begin
      s_o = 1'b0;
    end else if (ex <= 10'sd0) begin
      s_o = big.s;
    end else if (ex >= 10'sd255) begin
      s_o = big.s;
      e_o = 8'hff;
    end else begin
      s_o = big.s;
      e_o = ex[7:0];
      m_o = frac[6:0];
    end
  end

endmodule

// File: rtl/bf16_acc.sv
// Framed BF16 stream accumulator around bf16_add with valid/ready on both sides.
// Optional beat counter on cnt_o when BF16_ACC_CNT_EN is defined.
module bf16_acc
  import bf16_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             last_i,
  input  logic             s_i,
  input  logic [7:0]       e_i,
  input  logic [6:0]       m_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             s_o,
  output logic [7:0]       e_o,
  output logic [6:0]       m_o
`ifdef BF16_ACC_CNT_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  logic  first, take;
  bf16_t acc, opa, opb, sum;

  // First beat adds to +0 so sign-of-zero handling matches the adder
  assign opa     = first ? BF16_ZERO : acc;
  assign opb     = {s_i, e_i, m_i};
  assign ready_o = ~valid_o | ready_i;
  assign take    = valid_i & ready_o;

  bf16_add u_add (
    .a   (opa),
    .b   (opb),
    .s_o (sum.s),
    .e_o (sum.e),
    .m_o (sum.m)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first   <= 1'b1;
      acc     <= BF16_ZERO;
      valid_o <= 1'b0;
      s_o     <= 1'b0;
      e_o     <= 8'h00;
      m_o     <= 7'h00;
    end else begin
      if (valid_o && ready_i) valid_o <= 1'b0;
      if (take) begin
        if (last_i) begin
          {s_o, e_o, m_o} <= sum;
          valid_o         <= 1'b1;
          first           <= 1'b1;
          acc             <= BF16_ZERO;
        end else begin
          acc   <= sum;
          first <= 1'b0;
        end
      end
    end
  end

`ifdef BF16_ACC_CNT_EN
  logic [CNT_W-1:0] cnt, cnt_nx;

  always_comb begin
    cnt_nx = cnt + CNT_W'(1);
    if (first)   cnt_nx = CNT_W'(1);
    else if (&cnt) cnt_nx = cnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      cnt_o <= '0;
    end else if (take) begin
      if (last_i) begin
        cnt_o <= cnt_nx;
        cnt   <= '0;
      end else begin
        cnt <= cnt_nx;
      end
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_bf16_acc.sv
// Directed bench for bf16_acc; cnt_o checks are active when BF16_ACC_CNT_EN is defined.
module tb_bf16_acc;
  localparam int CNT_W = 2;

  logic       clk = 1'b0, rst = 1'b1;
  logic       valid_i = 1'b0, last_i = 1'b0, ready_i = 1'b1;
  logic       s_i = 1'b0;
  logic [7:0] e_i = 8'h00;
  logic [6:0] m_i = 7'h00;
  logic       ready_o, valid_o, s_o;
  logic [7:0] e_o;
  logic [6:0] m_o;
  logic [15:0] res;
`ifdef BF16_ACC_CNT_EN
  logic [CNT_W-1:0] cnt_o;
`endif
  int n_cmp = 0, n_bad = 0;

  assign res = {s_o, e_o, m_o};
  always #5 clk = ~clk;

  bf16_acc #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .last_i(last_i),
    .s_i(s_i), .e_i(e_i), .m_i(m_i), .valid_o(valid_o), .ready_i(ready_i),
    .s_o(s_o), .e_o(e_o), .m_o(m_o)
`ifdef BF16_ACC_CNT_EN
    , .cnt_o(cnt_o)
`endif
  );

  task automatic drive(input logic [15:0] v, input logic last);
    valid_i = 1'b1;
    {s_i, e_i, m_i} = v;
    last_i = last;
    @(posedge clk); #1;
    valid_i = 1'b0;
    last_i  = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid got %b exp 0", valid_o); end
    n_cmp++; if (res !== 16'h0000) begin n_bad++; $display("FAIL rst_res got %h exp 0000", res); end
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b exp 1", ready_o); end
`ifdef BF16_ACC_CNT_EN
    n_cmp++; if (cnt_o !== 2'd0) begin n_bad++; $display("FAIL rst_cnt got %0d exp 0", cnt_o); end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sum3;
    ready_i = 1'b1;
    drive(16'h3f80, 1'b0);
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL sum3_midvalid got %b exp 0", valid_o); end
    drive(16'h3f80, 1'b0);
    drive(16'h3f80, 1'b1);
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL sum3_valid got %b exp 1", valid_o); end
    n_cmp++; if (res !== 16'h4040) begin n_bad++; $display("FAIL sum3_res got %h exp 4040", res); end
`ifdef BF16_ACC_CNT_EN
    n_cmp++; if (cnt_o !== 2'd3) begin n_bad++; $display("FAIL sum3_cnt got %0d exp 3", cnt_o); end
`endif
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL sum3_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_back_to_back;
    drive(16'h8000, 1'b1);
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_v0 got %b exp 1", valid_o); end
    n_cmp++; if (res !== 16'h0000) begin n_bad++; $display("FAIL b2b_negzero got %h exp 0000", res); end
    drive(16'h4000, 1'b1);
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL b2b_v1 got %b exp 1", valid_o); end
    n_cmp++; if (res !== 16'h4000) begin n_bad++; $display("FAIL b2b_two got %h exp 4000", res); end
`ifdef BF16_ACC_CNT_EN
    n_cmp++; if (cnt_o !== 2'd1) begin n_bad++; $display("FAIL b2b_cnt got %0d exp 1", cnt_o); end
`endif
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL b2b_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_backpressure;
    ready_i = 1'b0;
    drive(16'h3f80, 1'b0);
    drive(16'h3f80, 1'b1);
    valid_i = 1'b1; {s_i, e_i, m_i} = 16'h3f80; last_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL bp_ready[%0d] got %b exp 0", c, ready_o); end
      n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d] got %b exp 1", c, valid_o); end
      n_cmp++; if (res !== 16'h4000) begin n_bad++; $display("FAIL bp_res[%0d] got %h exp 4000", c, res); end
`ifdef BF16_ACC_CNT_EN
      n_cmp++; if (cnt_o !== 2'd2) begin n_bad++; $display("FAIL bp_cnt[%0d] got %0d exp 2", c, cnt_o); end
`endif
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    #1;
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL bp_release got %b exp 1", ready_o); end
    @(posedge clk); #1;
    valid_i = 1'b0; last_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid got %b exp 1", valid_o); end
    n_cmp++; if (res !== 16'h3f80) begin n_bad++; $display("FAIL bp_next_res got %h exp 3f80", res); end
    @(posedge clk); #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL bp_drain got %b exp 0", valid_o); end
  endtask

  task automatic test_cancel;
    drive(16'h4000, 1'b0);
    drive(16'hc000, 1'b1);
    n_cmp++; if (res !== 16'h0000) begin n_bad++; $display("FAIL cancel_res got %h exp 0000", res); end
`ifdef BF16_ACC_CNT_EN
    n_cmp++; if (cnt_o !== 2'd2) begin n_bad++; $display("FAIL cancel_cnt got %0d exp 2", cnt_o); end
`endif
    drive(16'h3f80, 1'b1);
    n_cmp++; if (res !== 16'h3f80) begin n_bad++; $display("FAIL cancel_next got %h exp 3f80", res); end
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL cancel_valid got %b exp 1", valid_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    drive(16'h3f80, 1'b0);
    drive(16'h3f80, 1'b0);
    rst = 1'b1;
    #1;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b exp 0", valid_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(16'h3f80, 1'b1);
    n_cmp++; if (res !== 16'h3f80) begin n_bad++; $display("FAIL rmid_res got %h exp 3f80", res); end
`ifdef BF16_ACC_CNT_EN
    n_cmp++; if (cnt_o !== 2'd1) begin n_bad++; $display("FAIL rmid_cnt got %0d exp 1", cnt_o); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 5; i++) drive(16'h0000, (i == 4));
    n_cmp++; if (res !== 16'h0000) begin n_bad++; $display("FAIL sat_res got %h exp 0000", res); end
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL sat_valid got %b exp 1", valid_o); end
`ifdef BF16_ACC_CNT_EN
    n_cmp++; if (cnt_o !== 2'd3) begin n_bad++; $display("FAIL sat_cnt got %0d exp 3", cnt_o); end
`endif
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_sum3();
    test_back_to_back();
    test_backpressure();
    test_cancel();
    test_reset_mid();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bf16_acc.md
Name: bf16_acc

Overview:
- Sequential accumulator that sums a framed stream of BF16 operands into one BF16 result.
- Sits around the existing combinational bf16_add:
  - feeds it the running sum on port A and the incoming operand on port B;
  - registers its s_o/e_o/m_o outputs as the new running sum.
- Used downstream of operand producers (dot-product lanes) and upstream of result consumers, with valid/ready handshakes on both sides.

Parameters:
- CNT_W, 8, width of beat counter (only used when BF16_ACC_CNT_EN defined).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- valid_i  input  1  operand beat valid
- ready_o  output  1  block can accept operand beat
- last_i  input  1  beat is final beat of frame
- s_i  input  1  operand sign
- e_i  input  8  operand exponent
- m_i  input  7  operand mantissa
- valid_o  output  1  result valid
- ready_i  input  1  consumer accepts result
- s_o  output  1  result sign
- e_o  output  8  result exponent
- m_o  output  7  result mantissa
- cnt_o  output  CNT_W  beats in returned frame (BF16_ACC_CNT_EN only)

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high.
- Reset values:
  - valid_o=0; s_o/e_o/m_o=0; cnt_o=0.
  - Internal first flag=1; accumulator=+0.
- Beat accepted when valid_i & ready_o.
- ready_o = ~valid_o | ready_i (combinational). Result register is the only buffering.
- States, encoded by first flag and valid_o:
  - ACC_FIRST (first=1): next accepted beat starts a frame. Adder A operand forced to +0 (s=0, e=0, m=0); beat goes through bf16_add so zero-sign rules match the adder (-0 alone yields +0).
  - ACC_RUN (first=0): adder A operand = accumulator register; B = input beat.
  - On accept with last_i=0: accumulator <= adder output; first <= 0.
  - On accept with last_i=1:
    - result regs <= adder output; valid_o <= 1;
    - first <= 1; accumulator <= +0.
- Latency: result visible on valid_o the cycle after the last beat is accepted.
- Output hold: while valid_o=1 & ready_i=0, s_o/e_o/m_o/cnt_o stable, ready_o=0, no beats accepted.
- Output consumed (valid_o & ready_i): valid_o <= 0 unless a new last beat is accepted the same cycle; then valid_o stays 1 with new result.
- Back-to-back frames, including single-beat frames every cycle, sustain one result per cycle when ready_i=1.
- Single-beat frame (first and last together): result = +0 + operand via bf16_add.
- valid_i=0: no state change apart from output consumption.
- Reset mid-frame: partial sum discarded, first=1, pending result dropped.
- No internal rounding beyond bf16_add. Overflow/NaN propagation is whatever bf16_add returns.

Optional Feature:
- Macro: BF16_ACC_CNT_EN.
- Defined:
  - internal CNT_W-bit beat counter; resets to 0 on frame start;
  - increments per accepted beat; saturates at 2^CNT_W-1;
  - value including the last beat copied to cnt_o with the result.
- Undefined: cnt_o port and counter absent; no other behavioural change.

Decomposition:
- bf16_pkg:
  - bf16_t struct (s, e[7:0], m[6:0]);
  - BF16_ZERO constant;
  - BF16_ONE constant (0,8'h7f,0).
- Sub-module: one instance of existing bf16_add (combinational), no new sub-module.
- Control (first flag, output valid, counter) lives in bf16_acc.

Test Plan:
- Frame 1.0 (0,7f,00), 1.0, 1.0 last, ready_i=1 -> one cycle after last: valid_o=1, result (0,80,40)=3.0; with BF16_ACC_CNT_EN, cnt_o=3.
- Single-beat frame -0 (1,00,00) last -> result (0,00,00); next single-beat frame 2.0 (0,80,00) on following cycle -> (0,80,00), valid_o continuous.
- Backpressure: frame 1.0,1.0 last with ready_i=0 for 4 cycles -> ready_o=0, valid_o=1, result (0,80,00) stable; ready_i=1 -> accepted, ready_o=1 same cycle.
- Cancel: frame 2.0 (0,80,00), -2.0 (1,80,00) last -> result (0,00,00), no new frame corruption on next frame 1.0 last -> (0,7f,00).
- Reset mid-frame: 1.0, 1.0 accepted, rst pulsed -> valid_o=0; new frame 1.0 last -> (0,7f,00), not 3.0.
- Counter saturation (BF16_ACC_CNT_EN, CNT_W=2): frame of 5 zero beats -> result (0,00,00), cnt_o=3.
